// File: rtl/result_mux_arb_if.sv
// Handshake bundle for result_mux_arb: N_CH engine result streams in, one tagged result stream out.
// slave = selector side, master = driver/sink side.
interface result_mux_arb_if #(
  parameter int N_CH = 4,
  parameter int DW   = 128
);
  localparam int CW = $clog2(N_CH);

  logic                 mode_i;
  logic [CW-1:0]        sel_i;
  logic [N_CH*DW-1:0]   ch_data_i;
  logic [N_CH-1:0]      ch_valid_i;
  logic [N_CH-1:0]      ch_ready_o;
  logic [DW-1:0]        out_data_o;
  logic [CW-1:0]        out_id_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 err_o;

  modport slave (
    input  mode_i, sel_i, ch_data_i, ch_valid_i, out_ready_i,
    output ch_ready_o, out_data_o, out_id_o, out_valid_o, err_o
  );

  modport master (
    output mode_i, sel_i, ch_data_i, ch_valid_i, out_ready_i,
    input  ch_ready_o, out_data_o, out_id_o, out_valid_o, err_o
  );
endinterface

// File: rtl/result_mux_arb.sv
// Registered N_CH:1 result selector (fixed index or round-robin), one beat per transfer, tagged with source id.
// Optional fixed-mode idle watchdog with error beats: define RESULT_MUX_ARB_WDOG_EN.
module result_mux_arb #(
  parameter int N_CH    = 4,
  parameter int DW      = 128,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  result_mux_arb_if.slave  bus
);
  localparam int CW = $clog2(N_CH);

  logic [DW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_id_q, out_id_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q, err_d;
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;

  logic          load_s;
  logic          sel_ok_s;
  logic          grant_vld_s;
  logic [CW-1:0] grant_s;
  logic [CW-1:0] rr_idx_s;
  logic          rr_found_s;
  logic [CW-1:0] rr_g_s;
  logic [N_CH-1:0] ready_s;
  logic          xfer_s;
  logic          wdog_fire_s;

  assign load_s   = !out_valid_q || bus.out_ready_i;
  assign sel_ok_s = (int'(bus.sel_i) < N_CH);

  // Round-robin search starting just after the last granted channel
  always_comb begin
    rr_found_s = 1'b0;
    rr_g_s     = '0;
    rr_idx_s   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      rr_idx_s = CW'((int'(rr_ptr_q) + k) % N_CH);
      if (!rr_found_s && bus.ch_valid_i[rr_idx_s]) begin
        rr_found_s = 1'b1;
        rr_g_s     = rr_idx_s;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Grant selection and per-channel ready
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = '0;
    ready_s     = '0;
    if (bus.mode_i) begin
      grant_vld_s = rr_found_s;
      grant_s     = rr_g_s;
    end else begin
      grant_vld_s = sel_ok_s;
      grant_s     = bus.sel_i;
    end
    if (grant_vld_s && load_s && !clear_i) begin
      ready_s[grant_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign xfer_s = grant_vld_s && load_s && !clear_i && bus.ch_valid_i[grant_s];

`ifdef RESULT_MUX_ARB_WDOG_EN
  localparam int WB  = $clog2(TIMEOUT + 1);
  localparam int WDW = (WB < 8) ? 8 : ((WB > 32) ? 32 : WB);

  logic [WDW-1:0] wdog_q, wdog_d;
  logic [CW-1:0]  sel_q;

  // Idle watchdog: counts fixed-mode cycles where the selected channel could load but is silent
  always_comb begin
    wdog_d      = wdog_q;
    wdog_fire_s = 1'b0;
    if (clear_i) begin
      wdog_d = '0;
    end else if (xfer_s || bus.mode_i || (bus.sel_i != sel_q)) begin
      wdog_d = '0;
    end else if (load_s && sel_ok_s && (wdog_q == WDW'(TIMEOUT))) begin
      wdog_fire_s = 1'b1;
      wdog_d      = '0;
    end else if (load_s && sel_ok_s && !bus.ch_valid_i[bus.sel_i]) begin
      wdog_d = wdog_q + WDW'(1);
    end else begin
      wdog_d = wdog_q;
    end
  end

  // Watchdog state; sel_q remembers the previous select to spot changes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
      sel_q  <= '0;
    end else begin
      wdog_q <= wdog_d;
      sel_q  <= bus.sel_i;
    end
  end
`else
  assign wdog_fire_s = 1'b0;
`endif

  // Output register next state; clear beats transfer, transfer beats error beat, error beat beats drain
  always_comb begin
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    rr_ptr_d    = rr_ptr_q;
    if (clear_i) begin
      out_data_d  = '0;
      out_id_d    = '0;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      rr_ptr_d    = CW'(N_CH - 1);
    end else if (xfer_s) begin
      out_data_d  = bus.ch_data_i[int'(grant_s)*DW +: DW];
      out_id_d    = grant_s;
      out_valid_d = 1'b1;
      err_d       = 1'b0;
      if (bus.mode_i) begin
        rr_ptr_d = grant_s;
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else if (wdog_fire_s) begin
      out_data_d  = '0;
      out_id_d    = bus.sel_i;
      out_valid_d = 1'b1;
      err_d       = 1'b1;
    end else if (out_valid_q && bus.out_ready_i) begin
      out_valid_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output and round-robin pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rr_ptr_q    <= CW'(N_CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.ch_ready_o  = ready_s;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_id_o    = out_id_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_result_mux_arb.sv
// Bench for result_mux_arb: directed vector table plus randomized traffic against a behavioural model.
module tb_result_mux_arb;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  result_mux_arb_if #(.N_CH(N), .DW(DW)) bus ();

  result_mux_arb #(.N_CH(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clear_i(clear),
    .bus    (bus)
  );

  // Behavioural model state
  bit           m_valid;
  logic [DW-1:0] m_data;
  int           m_id;
  bit           m_err;
  int           m_ptr;
  int           m_wd;
  int           m_psel;

  typedef struct {
    logic       md;
    logic [1:0] sl;
    logic [3:0] vl;
    logic       rdy;
    logic       clr;
    logic [3:0] e_rdy;
    logic       e_vld;
    logic [1:0] e_id;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_id = 0; m_err = 1'b0; m_ptr = N - 1; m_wd = 0; m_psel = 0;
  endtask

  function automatic logic [DW-1:0] tbl_data(input int id);
    logic [DW-1:0] d;
    case (id)
      0: d = 128'd1;
      1: d = 128'd2;
      2: d = {16{8'hA5}};
      default: d = 128'd4;
    endcase
    return d;
  endfunction

  // One clock: drive, check outputs against the model, advance the model, pass the edge
  task automatic step(input logic md, input logic [1:0] sl, input logic [3:0] vl,
                      input logic rdy, input logic clr, output logic [3:0] got_rdy);
    bit ld, has, xfer, fire, sel_ok;
    int g;
    logic [3:0] er;
    bus.mode_i = md; bus.sel_i = sl; bus.ch_valid_i = vl; bus.out_ready_i = rdy; clear = clr;
    #2;
    ld = !m_valid || rdy;
    sel_ok = (int'(sl) < N);
    has = 1'b0; g = 0;
    if (!clr) begin
      if (!md) begin
        g = int'(sl); has = sel_ok;
      end else begin
        for (int off = 1; off <= N; off++) begin
          if (!has && vl[(m_ptr + off) % N]) begin
            has = 1'b1; g = (m_ptr + off) % N;
          end
        end
      end
    end
    er = (has && ld) ? (4'b0001 << g) : 4'b0000;
    got_rdy = bus.ch_ready_o;
    chk("ch_ready", 128'(bus.ch_ready_o), 128'(er));
    chk("out_valid", 128'(bus.out_valid_o), 128'(m_valid));
    chk("out_id", 128'(bus.out_id_o), 128'(m_id));
    chk("out_data", bus.out_data_o, m_data);
    chk("err", 128'(bus.err_o), 128'(m_err));
    xfer = has && ld && vl[g];
    fire = 1'b0;
`ifdef RESULT_MUX_ARB_WDOG_EN
    if (clr || xfer || md || int'(sl) != m_psel) m_wd = 0;
    else if (ld && sel_ok && m_wd == TO) begin fire = 1'b1; m_wd = 0; end
    else if (ld && sel_ok && !vl[sl]) m_wd++;
`endif
    m_psel = int'(sl);
    if (clr) begin
      m_valid = 1'b0; m_data = '0; m_id = 0; m_err = 1'b0; m_ptr = N - 1;
    end else if (xfer) begin
      m_valid = 1'b1; m_data = bus.ch_data_i[g*DW +: DW]; m_id = g; m_err = 1'b0;
      if (md) m_ptr = g;
    end else if (fire) begin
      m_valid = 1'b1; m_data = '0; m_id = int'(sl); m_err = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0; m_err = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] r;
    logic [DW-1:0] rd;
    bus.mode_i = 1'b0; bus.sel_i = 2'd0; bus.ch_valid_i = 4'b0000; bus.out_ready_i = 1'b0;
    for (int k = 0; k < N; k++) bus.ch_data_i[k*DW +: DW] = tbl_data(k);
    model_reset();

    // fixed sel=2, ch2 valid, then idle
    tbl.push_back('{1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2});
    tbl.push_back('{1'b0, 2'd2, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd2});
    // round-robin, all valid, 8 beats
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 1'b0, 4'(4'b0001 << (i % 4)), 1'b1, 2'(i % 4)});
    // round-robin over ch1/ch3 with a 5-cycle stall
    tbl.push_back('{1'b1, 2'd0, 4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b1, 2'd0, 4'b1010, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1});
    tbl.push_back('{1'b1, 2'd0, 4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3});
    tbl.push_back('{1'b1, 2'd0, 4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1});
    tbl.push_back('{1'b1, 2'd0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1});
    // fixed sel=3, clear while valid, then round-robin restarts at ch0
    tbl.push_back('{1'b0, 2'd3, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3});
    tbl.push_back('{1'b0, 2'd3, 4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0});
    tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0});
    tbl.push_back('{1'b1, 2'd0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 128'(bus.out_valid_o), 128'(0));
    chk("reset_data", bus.out_data_o, 128'(0));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].md, tbl[i].sl, tbl[i].vl, tbl[i].rdy, tbl[i].clr, r);
      chk($sformatf("vec%0d_ready", i), 128'(r), 128'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_valid", i), 128'(bus.out_valid_o), 128'(tbl[i].e_vld));
      chk($sformatf("vec%0d_id", i), 128'(bus.out_id_o), 128'(tbl[i].e_id));
      if (tbl[i].e_vld) chk($sformatf("vec%0d_data", i), bus.out_data_o, tbl_data(int'(tbl[i].e_id)));
    end

`ifdef RESULT_MUX_ARB_WDOG_EN
    for (int i = 0; i < 20; i++) step(1'b0, 2'd1, 4'b0000, 1'b1, 1'b0, r);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        rd = {$urandom, $urandom, $urandom, $urandom};
        bus.ch_data_i[k*DW +: DW] = rd;
      end
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0), r);
    end

    // async reset mid-stream with a beat held
    step(1'b1, 2'd0, 4'b1111, 1'b0, 1'b0, r);
    step(1'b1, 2'd0, 4'b1111, 1'b0, 1'b0, r);
    chk("pre_rst_valid", 128'(bus.out_valid_o), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 128'(bus.out_valid_o), 128'(0));
    chk("async_data", bus.out_data_o, 128'(0));
    chk("async_id", 128'(bus.out_id_o), 128'(0));
    chk("async_err", 128'(bus.err_o), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 2'd0, 4'b1111, 1'b1, 1'b0, r);
    step(1'b1, 2'd0, 4'b1111, 1'b1, 1'b0, r);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
